// File: rtl/register_write_port_if.sv
// Write-request bus for register_write_port: one valid/ready handshake that
// carries a 5-bit register index (class + x86 reg field) and LSB-aligned data.
interface register_write_port_if;
   logic        write_valid;
   logic        write_ready;
   logic [4:0]  write_index;
   logic [31:0] write_data;

   // Producer side: execute/load unit issuing write-back requests
   modport master (
      output write_valid,
      output write_index,
      output write_data,
      input  write_ready
   );

   // Consumer side: the register write port
   modport slave (
      input  write_valid,
      input  write_index,
      input  write_data,
      output write_ready
   );
endinterface

// File: rtl/register_write_port.sv
// register_write_port: buffers register write-back requests in a small
// in-order queue and commits one per cycle into the architectural GPR,
// segment-selector and EIP state, using x86 byte/word/dword merge rules.
// EIP is updated on its own path, independent of the queue.
module register_write_port #(
   parameter int          DEPTH     = 2,
   parameter logic [31:0] RESET_EIP = 32'h0000_FFF0,
   parameter logic [15:0] RESET_CS  = 16'hF000
) (
   input  logic                         clock,
   input  logic                         reset,
   register_write_port_if.slave         wr,
   input  logic                         flush,
   input  logic                         eip_load,
   input  logic [31:0]                  eip_value,
   input  logic [3:0]                   eip_advance,
   output logic [31:0]                  EAX,
   output logic [31:0]                  ECX,
   output logic [31:0]                  EDX,
   output logic [31:0]                  EBX,
   output logic [31:0]                  ESP,
   output logic [31:0]                  EBP,
   output logic [31:0]                  ESI,
   output logic [31:0]                  EDI,
   output logic [15:0]                  ES,
   output logic [15:0]                  CS,
   output logic [15:0]                  SS,
   output logic [15:0]                  DS,
   output logic [15:0]                  FS,
   output logic [15:0]                  GS,
   output logic [31:0]                  EIP,
   output logic [$clog2(DEPTH+1)-1:0]   pending_count,
   output logic                         empty,
   output logic                         error
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] ZERO_PTR = {PTR_W{1'b0}};

   localparam logic [1:0] CLS_R8   = 2'b00;
   localparam logic [1:0] CLS_R16  = 2'b01;
   localparam logic [1:0] CLS_R32  = 2'b10;
   localparam logic [1:0] CLS_SREG = 2'b11;

   // Circular-buffer pointer advance; wraps at DEPTH so non-power-of-two
   // depths work.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == LAST_PTR) begin
         n = ZERO_PTR;
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   // x86 partial-register merge: r8 writes one byte (low, or [15:8] for the
   // AH..BH encodings), r16 writes the low word, r32 replaces the register.
   function automatic logic [31:0] gpr_merge(
      input logic [31:0] old_val,
      input logic [1:0]  cls,
      input logic        high_byte,
      input logic [31:0] data
   );
      logic [31:0] res;
      case (cls)
         CLS_R8: begin
            if (high_byte) begin
               res = {old_val[31:16], data[7:0], old_val[7:0]};
            end else begin
               res = {old_val[31:8], data[7:0]};
            end
         end
         CLS_R16: res = {old_val[31:16], data[15:0]};
         CLS_R32: res = data;
         default: res = old_val;
      endcase
      return res;
   endfunction

   // Queue storage and bookkeeping
   logic [4:0]       q_index_r [DEPTH];
   logic [31:0]      q_data_r  [DEPTH];
   logic [PTR_W-1:0] head_r;
   logic [PTR_W-1:0] tail_r;
   logic [CNT_W-1:0] count_r;

   // Architectural state
   logic [31:0] gpr_r  [8];
   logic [15:0] sreg_r [6];
   logic [31:0] eip_r;
   logic        error_r;

   // Handshake / commit decode
   logic        ready_s;
   logic        push_s;
   logic        commit_s;
   logic [4:0]  head_index_s;
   logic [31:0] head_data_s;
   logic [1:0]  head_cls_s;
   logic [2:0]  gpr_sel_s;
   logic [31:0] gpr_new_s;
   logic        gpr_we_s;
   logic        sreg_we_s;
   logic        sreg_bad_s;

   // Ready depends only on held state plus flush/reset, never on write_valid.
   assign ready_s        = !reset && !flush && (count_r != FULL_CNT);
   assign wr.write_ready = ready_s;
   assign push_s         = wr.write_valid && ready_s;
   assign commit_s       = (count_r != ZERO_CNT) && !flush;

   // Decode the head entry into a target register and its merged new value
   always_comb begin
      head_index_s = q_index_r[head_r];
      head_data_s  = q_data_r[head_r];
      head_cls_s   = head_index_s[4:3];
      gpr_sel_s    = head_index_s[2:0];
      if (head_cls_s == CLS_R8) begin
         gpr_sel_s = {1'b0, head_index_s[1:0]};
      end else begin
         gpr_sel_s = head_index_s[2:0];
      end
      gpr_new_s  = gpr_merge(gpr_r[gpr_sel_s], head_cls_s, head_index_s[2], head_data_s);
      gpr_we_s   = commit_s && (head_cls_s != CLS_SREG);
      sreg_we_s  = 1'b0;
      sreg_bad_s = 1'b0;
      if (commit_s && (head_cls_s == CLS_SREG)) begin
         if (head_index_s[2:1] == 2'b11) begin
            sreg_bad_s = 1'b1;
         end else begin
            sreg_we_s = 1'b1;
         end
      end else begin
         sreg_we_s  = 1'b0;
         sreg_bad_s = 1'b0;
      end
   end

   // In-order write queue: enqueue at tail, dequeue the committed head, flush clears
   always_ff @(posedge clock) begin
      if (reset) begin
         head_r  <= ZERO_PTR;
         tail_r  <= ZERO_PTR;
         count_r <= ZERO_CNT;
         for (int i = 0; i < DEPTH; i++) begin
            q_index_r[i] <= 5'd0;
            q_data_r[i]  <= 32'd0;
         end
      end else if (flush) begin
         head_r  <= ZERO_PTR;
         tail_r  <= ZERO_PTR;
         count_r <= ZERO_CNT;
      end else begin
         if (push_s) begin
            q_index_r[tail_r] <= wr.write_index;
            q_data_r[tail_r]  <= wr.write_data;
            tail_r            <= ptr_next(tail_r);
         end
         if (commit_s) begin
            head_r <= ptr_next(head_r);
         end
         case ({push_s, commit_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Commit the head into GPR/segment state; illegal segment index latches error
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) begin
            gpr_r[i] <= 32'd0;
         end
         sreg_r[0] <= 16'd0;
         sreg_r[1] <= RESET_CS;
         sreg_r[2] <= 16'd0;
         sreg_r[3] <= 16'd0;
         sreg_r[4] <= 16'd0;
         sreg_r[5] <= 16'd0;
         error_r   <= 1'b0;
      end else begin
         if (gpr_we_s) begin
            gpr_r[gpr_sel_s] <= gpr_new_s;
         end
         if (sreg_we_s) begin
            sreg_r[head_index_s[2:0]] <= head_data_s[15:0];
         end
         if (sreg_bad_s) begin
            error_r <= 1'b1;
         end
      end
   end

   // Instruction pointer: explicit load wins over advance; advance wraps mod 2^32
   always_ff @(posedge clock) begin
      if (reset) begin
         eip_r <= RESET_EIP;
      end else if (eip_load) begin
         eip_r <= eip_value;
      end else begin
         eip_r <= eip_r + {28'd0, eip_advance};
      end
   end

   assign EAX = gpr_r[0];
   assign ECX = gpr_r[1];
   assign EDX = gpr_r[2];
   assign EBX = gpr_r[3];
   assign ESP = gpr_r[4];
   assign EBP = gpr_r[5];
   assign ESI = gpr_r[6];
   assign EDI = gpr_r[7];
   assign ES  = sreg_r[0];
   assign CS  = sreg_r[1];
   assign SS  = sreg_r[2];
   assign DS  = sreg_r[3];
   assign FS  = sreg_r[4];
   assign GS  = sreg_r[5];
   assign EIP = eip_r;

   assign pending_count = count_r;
   assign empty         = (count_r == ZERO_CNT);
   assign error         = error_r;

endmodule
